// File: rtl/timer_master_pkg.sv
// Shared types and register map for the interval-timer Avalon-MM initiator.
package timer_master_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CTRL_WR = 3'd1,
    RD_STAT = 3'd2,
    CHK     = 3'd3,
    CLR     = 3'd4
  } state_e;

  localparam int unsigned TMR_STATUS  = 0;
  localparam int unsigned TMR_CONTROL = 1;
  localparam int unsigned TMR_PERIODL = 2;
  localparam int unsigned TMR_PERIODH = 3;

  localparam int unsigned TO_BIT  = 0;
  localparam int unsigned RUN_BIT = 1;
  localparam int unsigned ITO_BIT = 0;

endpackage

// File: rtl/timer_irq_master_tick_prescaler.sv
// Divides serviced timeouts into events.
// Keeps a wrapping count of those events.
module tick_prescaler #(
  parameter int TICKS_PER_EVENT = 10,
  parameter int EVENT_CNT_W     = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   tick,
  output logic                   event_pulse,
  output logic [EVENT_CNT_W-1:0] event_count
);

  localparam int PW =
    (TICKS_PER_EVENT > 1) ? $clog2(TICKS_PER_EVENT) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICKS_PER_EVENT - 1);

  logic [PW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt         <= '0;
      event_pulse <= 1'b0;
      event_count <= '0;
    end else begin
      event_pulse <= 1'b0;
      if (tick) begin
        if (cnt == LAST) begin
          cnt         <= '0;
          event_pulse <= 1'b1;
          event_count <= event_count + EVENT_CNT_W'(1);
        end else begin
          cnt <= cnt + PW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/timer_irq_master.sv
// Services interval-timer timeouts over Avalon-MM without a CPU.
// Build option: TIMER_IRQ_MASTER_SPURIOUS_CNT_EN enables spurious_count.
module timer_irq_master #(
  parameter int TICKS_PER_EVENT = 10,
  parameter int EVENT_CNT_W     = 16,
  parameter int ADDR_W          = 3,
  parameter int DATA_W          = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   irq,
  output logic [ADDR_W-1:0]      m_address,
  output logic                   m_chipselect,
  output logic                   m_write_n,
  output logic [DATA_W-1:0]      m_writedata,
  input  logic [DATA_W-1:0]      m_readdata,
  output logic                   tick_pulse,
  output logic                   event_pulse,
  output logic [EVENT_CNT_W-1:0] event_count,
  output logic                   busy,
  output logic [7:0]             spurious_count
);

  import timer_master_pkg::*;

  state_e state;
  state_e state_nx;
  logic   ctrl_shadow;
  logic   to_seen;
  logic   unused_rd;

  assign to_seen   = m_readdata[TO_BIT];
  assign unused_rd = ^m_readdata;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (enable != ctrl_shadow)
          state_nx = CTRL_WR;
        else if (irq && ctrl_shadow)
          state_nx = RD_STAT;
      end
      CTRL_WR: state_nx = IDLE;
      RD_STAT: state_nx = CHK;
      CHK:     state_nx = to_seen ? CLR : IDLE;
      CLR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Bus outputs are decoded from the next state so each access
  // is visible during exactly the cycle its state is held.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      ctrl_shadow  <= 1'b0;
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      m_address    <= '0;
      m_writedata  <= '0;
      tick_pulse   <= 1'b0;
    end else begin
      state        <= state_nx;
      m_chipselect <= 1'b0;
      m_write_n    <= 1'b1;
      m_address    <= '0;
      m_writedata  <= '0;
      tick_pulse   <= (state == CLR);
      unique case (state_nx)
        CTRL_WR: begin
          m_chipselect <= 1'b1;
          m_write_n    <= 1'b0;
          m_address    <= ADDR_W'(TMR_CONTROL);
          m_writedata  <= DATA_W'(enable) << ITO_BIT;
          ctrl_shadow  <= enable;
        end
        RD_STAT: begin
          m_chipselect <= 1'b1;
          m_address    <= ADDR_W'(TMR_STATUS);
        end
        CLR: begin
          m_chipselect <= 1'b1;
          m_write_n    <= 1'b0;
          m_address    <= ADDR_W'(TMR_STATUS);
        end
        default: ;
      endcase
    end
  end

  tick_prescaler #(
    .TICKS_PER_EVENT(TICKS_PER_EVENT),
    .EVENT_CNT_W    (EVENT_CNT_W)
  ) u_presc (
    .clk        (clk),
    .reset_n    (reset_n),
    .tick       (state == CLR),
    .event_pulse(event_pulse),
    .event_count(event_count)
  );

`ifdef TIMER_IRQ_MASTER_SPURIOUS_CNT_EN
  logic [7:0] spur_q;

  always_ff @(posedge clk) begin
    if (!reset_n)
      spur_q <= 8'd0;
    else if (state == CHK && !to_seen && spur_q != 8'hff)
      spur_q <= spur_q + 8'd1;
  end

  assign spurious_count = spur_q;
`else
  assign spurious_count = 8'd0;
`endif

endmodule

// File: tb/tb_timer_irq_master.sv
// Directed table plus hand sequences for timer_irq_master.
module tb_timer_irq_master;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic        irq;
  logic [2:0]  m_address;
  logic        m_chipselect;
  logic        m_write_n;
  logic [15:0] m_writedata;
  logic [15:0] m_readdata;
  logic        tick_pulse;
  logic        event_pulse;
  logic [15:0] event_count;
  logic        busy;
  logic [7:0]  spurious_count;

  int n_cmp = 0;
  int n_bad = 0;
  int ticks = 0;
  logic [7:0] exp_spur;

  timer_irq_master #(
    .TICKS_PER_EVENT(10),
    .EVENT_CNT_W    (16),
    .ADDR_W         (3),
    .DATA_W         (16)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .irq           (irq),
    .m_address     (m_address),
    .m_chipselect  (m_chipselect),
    .m_write_n     (m_write_n),
    .m_writedata   (m_writedata),
    .m_readdata    (m_readdata),
    .tick_pulse    (tick_pulse),
    .event_pulse   (event_pulse),
    .event_count   (event_count),
    .busy          (busy),
    .spurious_count(spurious_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        en;
    logic        irq;
    logic [15:0] rd;
    logic        cs;
    logic        wn;
    logic [2:0]  addr;
    logic [15:0] wd;
    logic        tick;
    logic        busy;
  } vec_t;

  vec_t tbl[12];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bus_w(input logic cs, input logic wn,
                                        input logic [2:0] a,
                                        input logic [15:0] d);
    return {11'd0, cs, wn, a, d};
  endfunction

  task automatic chk_bus(input string name, input logic cs,
                         input logic wn, input logic [2:0] a,
                         input logic [15:0] d);
    chk(name, bus_w(m_chipselect, m_write_n, m_address, m_writedata),
        bus_w(cs, wn, a, d));
  endtask

  // One full timeout service starting from IDLE with irq raised.
  task automatic service(input string tag);
    logic ep;
    irq = 1'b1;
    m_readdata = 16'h0003;
    step();
    chk_bus({tag, " rd"}, 1'b1, 1'b1, 3'd0, 16'h0);
    step();
    chk({tag, " chk_idle"}, {31'd0, m_chipselect}, 32'd0);
    step();
    chk_bus({tag, " clr"}, 1'b1, 1'b0, 3'd0, 16'h0);
    irq = 1'b0;
    step();
    ticks++;
    ep = (ticks % 10 == 0);
    chk({tag, " tick/ev"}, {30'd0, tick_pulse, event_pulse},
        {30'd0, 1'b1, ep});
    chk({tag, " evcnt"}, {16'd0, event_count}, ticks / 10);
  endtask

  initial begin
    clk        = 1'b0;
    reset_n    = 1'b0;
    enable     = 1'b1;
    irq        = 1'b0;
    m_readdata = 16'h0003;

    tbl[0]  = '{1'b0, 1'b1, 1'b0, 16'h3, 1'b0, 1'b1, 3'd0, 16'h0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 16'h3, 1'b1, 1'b0, 3'd1, 16'h1, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 16'h3, 1'b0, 1'b1, 3'd0, 16'h0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 16'h3, 1'b1, 1'b1, 3'd0, 16'h0, 1'b0, 1'b1};
    tbl[4]  = '{1'b1, 1'b1, 1'b1, 16'h3, 1'b0, 1'b1, 3'd0, 16'h0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 16'h3, 1'b1, 1'b0, 3'd0, 16'h0, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 16'h3, 1'b0, 1'b1, 3'd0, 16'h0, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 16'h3, 1'b0, 1'b1, 3'd0, 16'h0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b1, 16'h2, 1'b1, 1'b1, 3'd0, 16'h0, 1'b0, 1'b1};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 16'h2, 1'b0, 1'b1, 3'd0, 16'h0, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 16'h2, 1'b0, 1'b1, 3'd0, 16'h0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 16'h2, 1'b0, 1'b1, 3'd0, 16'h0, 1'b0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      reset_n    = tbl[i].rst_n;
      enable     = tbl[i].en;
      irq        = tbl[i].irq;
      m_readdata = tbl[i].rd;
      step();
      chk_bus($sformatf("vec%0d bus", i), tbl[i].cs, tbl[i].wn,
              tbl[i].addr, tbl[i].wd);
      chk($sformatf("vec%0d tick/busy/ev", i),
          {29'd0, tick_pulse, busy, event_pulse},
          {29'd0, tbl[i].tick, tbl[i].busy, 1'b0});
    end
    ticks = 1;

`ifdef TIMER_IRQ_MASTER_SPURIOUS_CNT_EN
    exp_spur = 8'd1;
`else
    exp_spur = 8'd0;
`endif
    chk("spurious after table", {24'd0, spurious_count}, {24'd0, exp_spur});
    chk("evcnt after table", {16'd0, event_count}, 32'd0);

    // Nineteen more services: event on the 10th and 20th tick.
    for (int i = 0; i < 19; i++)
      service($sformatf("svc%0d", i + 2));
    chk("evcnt after 20", {16'd0, event_count}, 32'd2);

    // Enable falls during RD_STAT: service finishes, then control write 0.
    irq = 1'b1;
    step();
    chk_bus("en_drop rd", 1'b1, 1'b1, 3'd0, 16'h0);
    enable = 1'b0;
    step();
    chk("en_drop chk busy", {31'd0, busy}, 32'd1);
    step();
    chk_bus("en_drop clr", 1'b1, 1'b0, 3'd0, 16'h0);
    irq = 1'b0;
    step();
    chk("en_drop tick", {31'd0, tick_pulse}, 32'd1);
    ticks++;
    step();
    chk_bus("en_drop ctrl0", 1'b1, 1'b0, 3'd1, 16'h0);
    step();
    chk("en_drop idle", {30'd0, m_chipselect, busy}, 32'd0);
    irq = 1'b1;
    begin
      logic any_cs;
      any_cs = 1'b0;
      for (int i = 0; i < 6; i++) begin
        step();
        any_cs |= m_chipselect | busy | tick_pulse;
      end
      chk("disabled irq ignored", {31'd0, any_cs}, 32'd0);
    end
    irq = 1'b0;
    enable = 1'b1;
    step();
    chk_bus("re-enable ctrl1", 1'b1, 1'b0, 3'd1, 16'h1);
    step();

    // Reset during CHK, then CTRL_WR and service of the held irq.
    irq = 1'b1;
    m_readdata = 16'h0003;
    step();
    chk_bus("rst_mid rd", 1'b1, 1'b1, 3'd0, 16'h0);
    step();
    chk("rst_mid in chk", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    step();
    chk("rst_mid cs/busy/tick", {29'd0, m_chipselect, busy, tick_pulse},
        32'd0);
    chk("rst_mid evcnt", {16'd0, event_count}, 32'd0);
    chk("rst_mid spurious", {24'd0, spurious_count}, 32'd0);
    reset_n = 1'b1;
    step();
    chk_bus("rst_rel ctrl1", 1'b1, 1'b0, 3'd1, 16'h1);
    step();
    chk("rst_rel idle cs", {31'd0, m_chipselect}, 32'd0);
    step();
    chk_bus("rst_rel rd", 1'b1, 1'b1, 3'd0, 16'h0);
    step();
    step();
    chk_bus("rst_rel clr", 1'b1, 1'b0, 3'd0, 16'h0);
    irq = 1'b0;
    step();
    chk("rst_rel tick/ev", {30'd0, tick_pulse, event_pulse}, 32'd2);
    chk("rst_rel evcnt", {16'd0, event_count}, 32'd0);
    step();
    chk("rst_rel single tick", {30'd0, tick_pulse, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
